// File: rtl/pwm_audio_pkg.sv
// Shared definitions for the PWM audio transmit path and its receive-side demodulator.
package pwm_audio_pkg;

    localparam int PWM_PERIOD = 4095;
    localparam int SAMPLE_W   = 12;
    localparam int TOL        = 2;
    localparam int ERR_LIMIT  = 4;

    typedef logic [SAMPLE_W-1:0] sample_t;

    typedef enum logic {
        HUNT,
        TRACK
    } demod_state_t;

endpackage

// File: rtl/pwm_sync_edge.sv
// Brings the asynchronous PWM pin into the clk domain and flags its rising edges.
module pwm_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    output logic s,
    output logic rise
);

    logic meta;
    logic s_d;

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            s    <= 1'b0;
            s_d  <= 1'b0;
        end else begin
            meta <= pwm_in;
            s    <= meta;
            s_d  <= s;
        end
    end

    assign rise = s & ~s_d;

endmodule

// File: rtl/pwm_audio_demod.sv
// Locks to the frame period of a 1-bit PWM audio stream and returns each frame's high-time
// as a sample over a valid/ready interface.
module pwm_audio_demod #(
    parameter int PWM_PERIOD = pwm_audio_pkg::PWM_PERIOD,
    parameter int SAMPLE_W   = pwm_audio_pkg::SAMPLE_W,
    parameter int TOL        = pwm_audio_pkg::TOL,
    parameter int ERR_LIMIT  = pwm_audio_pkg::ERR_LIMIT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pwm_in,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                locked,
    output logic                period_err,
    output logic                overrun,
    input  logic                overrun_clr
);

    import pwm_audio_pkg::*;

    localparam int                  ERR_W    = $clog2(ERR_LIMIT + 1);
    localparam logic [SAMPLE_W-1:0] PERIOD_V = SAMPLE_W'(PWM_PERIOD);

    demod_state_t        state;
    logic [SAMPLE_W-1:0] win_len;
    logic [SAMPLE_W-1:0] hi_cnt;
    logic [ERR_W-1:0]    err_run;
    logic                s;
    logic                rise;
    logic                boundary;
    logic                off_tol;
    logic                slot_free;

    pwm_sync_edge u_sync (
        .clk    (clk),
        .rst    (rst),
        .pwm_in (pwm_in),
        .s      (s),
        .rise   (rise)
    );

    // A rise landing exactly on a full window closes one frame, not two.
    assign boundary  = rise | (win_len == PERIOD_V);
    assign off_tol   = (int'(win_len) < PWM_PERIOD - TOL) || (int'(win_len) > PWM_PERIOD + TOL);
    assign slot_free = ~sample_valid | sample_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= HUNT;
            win_len      <= '0;
            hi_cnt       <= '0;
            err_run      <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            locked       <= 1'b0;
            period_err   <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            period_err <= 1'b0;

            if (overrun_clr) begin
                overrun <= 1'b0;
            end
            if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end

            if (boundary) begin
                win_len <= SAMPLE_W'(1);
                hi_cnt  <= SAMPLE_W'(s);
            end else begin
                win_len <= win_len + SAMPLE_W'(1);
                hi_cnt  <= hi_cnt + SAMPLE_W'(s);
            end

            if (boundary) begin
                case (state)
                    HUNT: begin
                        state   <= TRACK;
                        locked  <= 1'b1;
                        err_run <= '0;
                    end
                    TRACK: begin
                        // A full slot keeps its value; the newer frame is the one dropped.
                        if (slot_free) begin
                            sample       <= hi_cnt;
                            sample_valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end

                        if (rise && off_tol) begin
                            period_err <= 1'b1;
                            if (err_run == ERR_W'(ERR_LIMIT - 1)) begin
                                state   <= HUNT;
                                locked  <= 1'b0;
                                err_run <= '0;
                            end else begin
                                err_run <= err_run + ERR_W'(1);
                            end
                        end else begin
                            err_run <= '0;
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_audio_demod.sv
// Scoreboard bench for pwm_audio_demod: directed PWM streams with hand-computed frame samples.
module tb_pwm_audio_demod;

    localparam int P = 4095;

    logic        clk = 1'b0;
    logic        rst;
    logic        pwm_in;
    logic [11:0] sample;
    logic        sample_valid;
    logic        sample_ready;
    logic        locked;
    logic        period_err;
    logic        overrun;
    logic        overrun_clr;

    int checks = 0;
    int errors = 0;

    int    exp_val[$];
    bit    exp_err[$];
    string exp_tag[$];
    bit    err_seen = 1'b0;

    int duty_req = 0;
    int duty_cur = 0;
    int cnt      = 0;
    bit inject   = 1'b0;

    always #10 clk = ~clk;

    pwm_audio_demod dut (
        .clk          (clk),
        .rst          (rst),
        .pwm_in       (pwm_in),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .locked       (locked),
        .period_err   (period_err),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic expect_sample(input int value, input bit err, input string tag);
        exp_val.push_back(value);
        exp_err.push_back(err);
        exp_tag.push_back(tag);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input int n);
        repeat (n) tick();
    endtask

    // pwm_audio-style source: duty latched at frame start, optional 2-cycle dip at 498..499.
    task automatic pwm_run(input int n);
        for (int i = 0; i < n; i++) begin
            if (cnt == 0) duty_cur = duty_req;
            pwm_in = (cnt < duty_cur) && !(inject && (cnt == 498 || cnt == 499));
            cnt = (cnt + 1) % P;
            tick();
        end
    endtask

    // Monitor: a sample is consumed when valid & ready are seen ahead of the clock edge.
    always @(negedge clk) begin
        if (rst) begin
            err_seen = 1'b0;
        end else begin
            if (period_err) err_seen = 1'b1;
            if (sample_valid && sample_ready) begin
                if (exp_val.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_sample: got %0d, expected no sample", sample);
                end else begin
                    automatic int    v = exp_val.pop_front();
                    automatic bit    e = exp_err.pop_front();
                    automatic string t = exp_tag.pop_front();
                    check({"sample_", t}, sample, v);
                    check({"period_err_", t}, err_seen, e);
                end
                err_seen = 1'b0;
            end
        end
    end

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog: got no finish, expected finish within 150000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        pwm_in       = 1'b0;
        sample_ready = 1'b1;
        overrun_clr  = 1'b0;
        hold(3);
        @(negedge clk);
        check("reset_sample", sample, 0);
        check("reset_sample_valid", sample_valid, 0);
        check("reset_locked", locked, 0);
        check("reset_period_err", period_err, 0);
        check("reset_overrun", overrun, 0);
        rst = 1'b0;

        // Constant low: free-running lock after one full window, then zero samples.
        hold(4000);
        @(negedge clk);
        check("hunt_before_timeout", locked, 0);
        hold(100);
        @(negedge clk);
        check("lock_on_constant_low", locked, 1);
        expect_sample(0, 1'b0, "low_timeout");
        hold(4110);
        // Rising to constant high: short first frame is an error, then full-scale timeouts.
        expect_sample(0, 1'b1, "short_frame_at_rise");
        expect_sample(4095, 1'b0, "high_timeout");
        pwm_in = 1'b1;
        hold(4200);
        hold(2000);

        // One-cycle reset in the middle of a frame.
        pwm_in = 1'b0;
        rst    = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midreset_sample", sample, 0);
        check("midreset_sample_valid", sample_valid, 0);
        check("midreset_locked", locked, 0);
        check("midreset_period_err", period_err, 0);
        check("midreset_overrun", overrun, 0);
        check("queue_empty_before_stream", exp_val.size(), 0);

        // Steady duty 1000, then a step to 3000 mid-frame.
        cnt      = 0;
        duty_req = 1000;
        pwm_run(20);
        @(negedge clk);
        check("relock_after_reset", locked, 1);
        expect_sample(1000, 1'b0, "duty1000_a");
        expect_sample(1000, 1'b0, "duty1000_b");
        pwm_run(P - 20 + P);
        expect_sample(1000, 1'b0, "frame_at_step");
        pwm_run(2000);
        duty_req = 3000;
        pwm_run(P - 2000);
        expect_sample(3000, 1'b0, "after_step");
        pwm_run(P);

        // Extra rise 500 cycles in: each injected period yields a short and a long bad frame.
        inject = 1'b1;
        expect_sample(498, 1'b1, "inj1_short");
        expect_sample(2500, 1'b1, "inj1_long");
        expect_sample(498, 1'b1, "inj2_short");
        expect_sample(2500, 1'b1, "inj2_long_unlock");
        pwm_run(P);
        pwm_run(1000);
        @(negedge clk);
        check("locked_after_3_errors", locked, 1);
        pwm_run(P - 1000);
        inject = 1'b0;
        pwm_run(20);
        @(negedge clk);
        check("unlocked_after_4_errors", locked, 0);
        expect_sample(3000, 1'b0, "after_relock");
        pwm_run(P - 20);
        pwm_run(20);
        @(negedge clk);
        check("relock_after_errors", locked, 1);
        duty_req = 2048;
        pwm_run(P - 20);

        // Backpressure across three frame closes.
        pwm_run(100);
        sample_ready = 1'b0;
        expect_sample(2048, 1'b0, "held_2048");
        pwm_run(P - 100);
        pwm_run(100);
        @(negedge clk);
        check("bp1_sample_valid", sample_valid, 1);
        check("bp1_sample", sample, 2048);
        check("bp1_overrun", overrun, 0);
        pwm_run(P - 100);
        pwm_run(100);
        @(negedge clk);
        check("bp2_sample", sample, 2048);
        check("bp2_overrun", overrun, 1);
        pwm_run(P - 100);
        pwm_run(100);
        @(negedge clk);
        check("bp3_sample", sample, 2048);
        check("bp3_sample_valid", sample_valid, 1);
        check("bp3_overrun", overrun, 1);
        overrun_clr = 1'b1;
        pwm_run(1);
        overrun_clr = 1'b0;
        @(negedge clk);
        check("overrun_cleared", overrun, 0);
        sample_ready = 1'b1;
        pwm_run(10);

        for (int i = 0; i < 100 && exp_val.size() != 0; i++) tick();
        check("queue_drained", exp_val.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
